// File: rtl/async_fifo_rd_axis.sv
// async_fifo_rd_axis
//   Read-side adapter for async_fifo in the rd_clk domain. It drains the FIFO read port into
//   a 2-entry registered buffer and presents the words as an AXI4-Stream master. The buffer
//   sustains one beat per clock, and every AXI output comes straight from a flop.
//
// Ports
//   clk            rd-side clock (same net as async_fifo rd_clk)
//   reset          synchronous active-high reset
//   fifo_rd_empty  async_fifo rd_empty
//   fifo_rd_data   async_fifo head word, valid while fifo_rd_empty=0
//   fifo_rd_en     async_fifo rd_en (pop)
//   m_tvalid       AXI-Stream valid
//   m_tready       AXI-Stream ready
//   m_tdata        AXI-Stream data (W bits, or W-1 bits with the tlast option)
//   m_tlast        AXI-Stream last (tlast option only)
//   beat_count     accepted-beat counter, wraps
//   buf_level      output buffer occupancy 0..2
//
// Optional feature: define ASYNC_FIFO_RD_AXIS_TLAST_EN to treat fifo_rd_data[W-1] as the
// packet-end flag driven on m_tlast; m_tdata then carries fifo_rd_data[W-2:0].
module async_fifo_rd_axis #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_rd_empty,
  input  logic [W-1:0]     fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_tvalid,
  input  logic             m_tready,
`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
  output logic [W-2:0]     m_tdata,
  output logic             m_tlast,
`else
  output logic [W-1:0]     m_tdata,
`endif
  output logic [CNT_W-1:0] beat_count,
  output logic [1:0]       buf_level
);

  logic [1:0]       r_level;
  logic             r_tvalid;
  logic [W-1:0]     r_e0;
  logic [W-1:0]     r_e1;
  logic [CNT_W-1:0] r_beats;

  logic [1:0]       w_level_nxt;
  logic [W-1:0]     w_e0_nxt;
  logic [W-1:0]     w_e1_nxt;
  logic             w_pop;
  logic             w_acc;

  // Pop depends only on registered occupancy and the FIFO flag; m_tready never reaches rd_en.
  assign w_pop      = ~reset & ~fifo_rd_empty & (r_level != 2'd2);
  assign w_acc      = r_tvalid & m_tready;
  assign fifo_rd_en = w_pop;

  always_comb begin
    w_level_nxt = r_level;
    w_e0_nxt    = r_e0;
    w_e1_nxt    = r_e1;
    case (r_level)
      2'd0: begin
        if (w_pop) begin
          w_e0_nxt    = fifo_rd_data;
          w_level_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (w_pop && w_acc) begin
          w_e0_nxt = fifo_rd_data;
        end else if (w_pop) begin
          w_e1_nxt    = fifo_rd_data;
          w_level_nxt = 2'd2;
        end else if (w_acc) begin
          w_level_nxt = 2'd0;
        end
      end
      2'd2: begin
        // No pop is possible at full occupancy; an accept promotes the skid entry.
        if (w_acc) begin
          w_e0_nxt    = r_e1;
          w_level_nxt = 2'd1;
        end
      end
      default: w_level_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level  <= 2'd0;
      r_tvalid <= 1'b0;
      r_e0     <= '0;
      r_e1     <= '0;
      r_beats  <= '0;
    end else begin
      r_level  <= w_level_nxt;
      r_tvalid <= (w_level_nxt != 2'd0);
      r_e0     <= w_e0_nxt;
      r_e1     <= w_e1_nxt;
      if (w_acc) begin
        r_beats <= r_beats + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign m_tvalid   = r_tvalid;
  assign buf_level  = r_level;
  assign beat_count = r_beats;
`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
  assign m_tdata    = r_e0[W-2:0];
  assign m_tlast    = r_e0[W-1];
`else
  assign m_tdata    = r_e0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_axis.sv
// Randomized self-checking bench for async_fifo_rd_axis. The FIFO is a queue; the expected
// output buffer is the queue of words popped but not yet accepted.
module tb_async_fifo_rd_axis;

`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
  localparam int unsigned W = 9;
`else
  localparam int unsigned W = 8;
`endif
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_rd_empty;
  logic [W-1:0]     fifo_rd_data;
  logic             fifo_rd_en;
  logic             m_tvalid;
  logic             m_tready;
`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
  logic [W-2:0]     m_tdata;
  logic             m_tlast;
`else
  logic [W-1:0]     m_tdata;
`endif
  logic [CNT_W-1:0] beat_count;
  logic [1:0]       buf_level;

  async_fifo_rd_axis #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
    .m_tlast      (m_tlast),
`endif
    .beat_count   (beat_count),
    .buf_level    (buf_level)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [W-1:0]     src_q[$];
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     got_q[$];
  logic [CNT_W-1:0] beat_model = '0;
  int unsigned      n_pop = 0;
  int unsigned      n_acc = 0;
  int unsigned      cyc = 0;
  bit               last_pop, last_acc, last_valid;
  logic [W-1:0]     last_obs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] obs_word();
`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
    return {m_tlast, m_tdata};
`else
    return m_tdata;
`endif
  endfunction

  // One clock: drive inputs after negedge, check against the model, then advance the model.
  task automatic step(input bit rdy, input bit gate, input bit rst);
    bit pop, acc;
    @(negedge clk);
    reset         = rst;
    m_tready      = rdy;
    fifo_rd_empty = gate || (src_q.size() == 0);
    fifo_rd_data  = (src_q.size() != 0) ? src_q[0] : W'($urandom);
    #1;
    check_eq("rd_en_while_empty", 32'(fifo_rd_en & fifo_rd_empty), 32'd0);
    check_eq("rd_en", 32'(fifo_rd_en),
             32'(!rst && !fifo_rd_empty && exp_q.size() < 2));
    check_eq("buf_level", 32'(buf_level), 32'(exp_q.size()));
    check_eq("tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq("tdata_order", 32'(obs_word()), 32'(exp_q[0]));
    check_eq("beat_count", 32'(beat_count), 32'(beat_model));
    pop        = fifo_rd_en;
    acc        = m_tvalid && m_tready;
    last_pop   = pop;
    last_acc   = acc;
    last_valid = m_tvalid;
    last_obs   = obs_word();
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      src_q.delete();
      beat_model = '0;
    end else begin
      if (acc) begin
        got_q.push_back(exp_q.pop_front());
        beat_model = beat_model + 1'b1;
        n_acc++;
      end
      if (pop) begin
        exp_q.push_back(src_q.pop_front());
        n_pop++;
      end
    end
  endtask

  initial begin
    int first_beat, last_beat, guard, pushed;
    reset = 1'b1; m_tready = 1'b0; fifo_rd_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(obs_word()), 32'd0);
    check_eq("rst_level", 32'(buf_level), 32'd0);
    check_eq("rst_beats", 32'(beat_count), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // Empty FIFO idle.
    repeat (20) step(1'b1, 1'b1, 1'b0);

    // Single-word latency.
    src_q.push_back(W'(8'h11));
    step(1'b1, 1'b0, 1'b0);
    check_eq("lat_pop", 32'(last_pop), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check_eq("lat_valid", 32'(last_valid), 32'd1);
    check_eq("lat_data", 32'(last_obs), 32'h11);
    check_eq("lat_acc", 32'(last_acc), 32'd1);
    #1 check_eq("lat_beats", 32'(beat_count), 32'd1);
    got_q.delete();

    // Backpressure with 8 words queued, then drain.
    for (int i = 0; i < 8; i++) src_q.push_back(W'(i));
    n_pop = 0;
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check_eq("bp_pops", n_pop, 32'd2);
    check_eq("bp_level", 32'(buf_level), 32'd2);
    check_eq("bp_hold_data", 32'(obs_word()), 32'd0);
    n_acc = 0; first_beat = -1; last_beat = -1; guard = 0;
    while (n_acc < 8 && guard < 40) begin
      step(1'b1, 1'b0, 1'b0);
      if (last_acc) begin
        if (first_beat < 0) first_beat = guard;
        last_beat = guard;
      end
      guard++;
    end
    check_eq("drain_count", n_acc, 32'd8);
    check_eq("drain_span", 32'(last_beat - first_beat + 1), 32'd8);
    for (int i = 0; i < 8; i++)
      check_eq("drain_order", 32'(got_q.size() > i ? got_q[i] : '1), 32'(i));
    got_q.delete();

    // Random ready and empty gating over 1000 words.
    n_acc = 0; pushed = 0; guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      if (pushed < 1000 && src_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(W'($urandom));
        pushed++;
      end
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 9) < 3, 1'b0);
      guard++;
    end
    check_eq("rand_delivered", n_acc, 32'd1000);
    check_eq("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    got_q.delete();

    // Reset while full.
    for (int i = 0; i < 3; i++) src_q.push_back(W'(8'h40 + i));
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_level", 32'(buf_level), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    #1;
    check_eq("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("mid_rst_level", 32'(buf_level), 32'd0);
    check_eq("mid_rst_beats", 32'(beat_count), 32'd0);
    check_eq("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0);

`ifdef ASYNC_FIFO_RD_AXIS_TLAST_EN
    got_q.delete();
    src_q.push_back(9'h0AA);
    src_q.push_back(9'h1BB);
    guard = 0;
    while (got_q.size() < 2 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_eq("tlast_beats", 32'(got_q.size()), 32'd2);
    check_eq("tlast_beat0", 32'(got_q.size() > 0 ? got_q[0] : '0), 32'h0AA);
    check_eq("tlast_beat1", 32'(got_q.size() > 1 ? got_q[1] : '0), 32'h1BB);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
